// File: rtl/csr_timer_intc_pkg.sv
// csr_timer_intc_pkg: CSR numbers, TCFG fields, IS indices and timer state shared with the CSR unit
package csr_timer_intc_pkg;
    localparam logic [13:0] CSR_TID   = 14'h40;
    localparam logic [13:0] CSR_TCFG  = 14'h41;
    localparam logic [13:0] CSR_TVAL  = 14'h42;
    localparam logic [13:0] CSR_TICLR = 14'h44;
    localparam int TCFG_EN          = 0;
    localparam int TCFG_PERIODIC    = 1;
    localparam int TCFG_INITVAL_LSB = 2;
    localparam int IS_TI  = 11;
    localparam int IS_IPI = 12;
    typedef enum logic {TIMER_IDLE, TIMER_COUNT} timer_state_e;
endpackage

// File: rtl/csr_timer_core.sv
// csr_timer_core: TCFG/TVAL registers and countdown FSM that raises TI
module csr_timer_core
    import csr_timer_intc_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tcfg_we,
    input  logic [TIMER_W-1:0] wmask,
    input  logic [TIMER_W-1:0] wvalue,
    input  logic               ticlr,
    output logic [31:0]        tcfg,
    output logic [31:0]        tval,
    output logic               ti
);
    timer_state_e state, state_n;
    logic [TIMER_W-1:0] cfg, cfg_n, cnt, cnt_n, cfg_wr, reload_wr, reload_cur;
    logic ti_n;
    assign cfg_wr     = (cfg & ~wmask) | (wvalue & wmask);
    assign reload_wr  = cfg_wr & ~TIMER_W'(3);
    assign reload_cur = cfg & ~TIMER_W'(3);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= TIMER_IDLE;
            cfg   <= '0;
            cnt   <= '0;
            ti    <= 1'b0;
        end else begin
            state <= state_n;
            cfg   <= cfg_n;
            cnt   <= cnt_n;
            ti    <= ti_n;
        end
    end
    // A TCFG write overrides expiry; an expiry overrides a same-cycle clear.
    always_comb begin
        state_n = state;
        cfg_n   = cfg;
        cnt_n   = cnt;
        ti_n    = ti & ~ticlr;
        if (tcfg_we) begin
            cfg_n   = cfg_wr;
            state_n = cfg_wr[TCFG_EN] ? TIMER_COUNT : TIMER_IDLE;
            cnt_n   = cfg_wr[TCFG_EN] ? reload_wr : cnt;
        end else if (state == TIMER_COUNT && cnt != '0) begin
            cnt_n = cnt - TIMER_W'(1);
        end else if (state == TIMER_COUNT) begin
            ti_n    = 1'b1;
            state_n = cfg[TCFG_PERIODIC] ? TIMER_COUNT : TIMER_IDLE;
            cnt_n   = cfg[TCFG_PERIODIC] ? reload_cur : cnt;
        end
    end
    assign tcfg = 32'(cfg);
    assign tval = 32'(cnt);
endmodule

// File: rtl/csr_timer_intc.sv
// csr_timer_intc: timer/TID/stable-counter CSRs, ESTAT.IS pending vector and registered has_int
module csr_timer_intc
    import csr_timer_intc_pkg::*;
#(
    parameter int          TIMER_W = 32,
    parameter logic [31:0] TID_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_we,
    input  logic [13:0] csr_wnum,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic [13:0] csr_rnum,
    output logic [31:0] csr_rvalue,
    output logic        csr_hit,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_in,
    input  logic [1:0]  swi,
    input  logic [12:0] ecfg_lie,
    input  logic        crmd_ie,
    output logic [12:0] estat_is,
    output logic        has_int,
    output logic [31:0] tid,
    output logic [63:0] stable_cnt
);
    logic [31:0] tcfg, tval;
    logic [7:0] hw_q;
    logic ipi_q, ti, tcfg_we, ticlr;
    assign tcfg_we = csr_we && csr_wnum == CSR_TCFG;
    assign ticlr   = csr_we && csr_wnum == CSR_TICLR && csr_wmask[0] && csr_wvalue[0];
    csr_timer_core #(.TIMER_W(TIMER_W)) u_core (
        .clk    (clk),
        .reset  (reset),
        .tcfg_we(tcfg_we),
        .wmask  (csr_wmask[TIMER_W-1:0]),
        .wvalue (csr_wvalue[TIMER_W-1:0]),
        .ticlr  (ticlr),
        .tcfg   (tcfg),
        .tval   (tval),
        .ti     (ti)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            tid        <= TID_RST;
            stable_cnt <= '0;
            hw_q       <= '0;
            ipi_q      <= 1'b0;
            has_int    <= 1'b0;
        end else begin
            stable_cnt <= stable_cnt + 64'd1;
            if (csr_we && csr_wnum == CSR_TID)
                tid <= (tid & ~csr_wmask) | (csr_wvalue & csr_wmask);
            hw_q    <= hw_int_in;
            ipi_q   <= ipi_in;
            has_int <= crmd_ie & |(estat_is & ecfg_lie);
        end
    end
    assign estat_is   = {ipi_q, ti, 1'b0, hw_q, swi};
    assign csr_rvalue = csr_rnum == CSR_TID  ? tid  :
                        csr_rnum == CSR_TCFG ? tcfg :
                        csr_rnum == CSR_TVAL ? tval : 32'h0;
    assign csr_hit    = csr_rnum inside {CSR_TID, CSR_TCFG, CSR_TVAL, CSR_TICLR};
endmodule

// File: tb/tb_csr_timer_intc.sv
// tb_csr_timer_intc: directed timer scenarios plus random traffic checked against a cycle model
module tb_csr_timer_intc;
    logic        clk = 1'b0;
    logic        reset, csr_we, csr_hit, ipi_in, crmd_ie, has_int;
    logic [13:0] csr_wnum, csr_rnum;
    logic [31:0] csr_wmask, csr_wvalue, csr_rvalue, tid;
    logic [7:0]  hw_int_in;
    logic [1:0]  swi;
    logic [12:0] ecfg_lie, estat_is;
    logic [63:0] stable_cnt;
    int tests = 0, fails = 0;

    csr_timer_intc dut (
        .clk(clk), .reset(reset), .csr_we(csr_we), .csr_wnum(csr_wnum),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rnum(csr_rnum),
        .csr_rvalue(csr_rvalue), .csr_hit(csr_hit), .hw_int_in(hw_int_in),
        .ipi_in(ipi_in), .swi(swi), .ecfg_lie(ecfg_lie), .crmd_ie(crmd_ie),
        .estat_is(estat_is), .has_int(has_int), .tid(tid), .stable_cnt(stable_cnt)
    );

    always #5 clk = ~clk;

    // Reference: timer as "running" flag plus remaining count, everything else as plain registers.
    logic [63:0] m_cnt;
    logic [31:0] m_tid, m_tcfg, m_tval;
    logic [7:0]  m_hw;
    logic        m_run, m_ti, m_ipi, m_has;
    logic        mvalid = 1'b0;

    function automatic logic [12:0] m_is();
        return {m_ipi, m_ti, 1'b0, m_hw, swi};
    endfunction

    function automatic logic [31:0] m_rd(input logic [13:0] n);
        return n == 14'h40 ? m_tid : n == 14'h41 ? m_tcfg : n == 14'h42 ? m_tval : 32'h0;
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] tcfg_n, tval_n, nt;
        logic run_n, ti_n;
        if (reset) begin
            m_cnt <= 0; m_tid <= 0; m_tcfg <= 0; m_tval <= 0; m_run <= 0;
            m_ti <= 0; m_hw <= 0; m_ipi <= 0; m_has <= 0; mvalid <= 1;
        end else begin
            tcfg_n = m_tcfg; tval_n = m_tval; run_n = m_run; ti_n = m_ti;
            if (csr_we && csr_wnum == 14'h44 && csr_wmask[0] && csr_wvalue[0]) ti_n = 0;
            if (csr_we && csr_wnum == 14'h41) begin
                nt = (m_tcfg & ~csr_wmask) | (csr_wvalue & csr_wmask);
                tcfg_n = nt;
                run_n = nt[0];
                if (nt[0]) tval_n = nt / 4 * 4;
            end else if (m_run && m_tval == 0) begin
                ti_n = 1;
                if (m_tcfg[1]) tval_n = m_tcfg / 4 * 4;
                else run_n = 0;
            end else if (m_run) begin
                tval_n = m_tval - 1;
            end
            if (csr_we && csr_wnum == 14'h40)
                m_tid <= (m_tid & ~csr_wmask) | (csr_wvalue & csr_wmask);
            m_has  <= crmd_ie && ((m_is() & ecfg_lie) != 0);
            m_cnt  <= m_cnt + 1;
            m_tcfg <= tcfg_n; m_tval <= tval_n; m_run <= run_n; m_ti <= ti_n;
            m_hw   <= hw_int_in; m_ipi <= ipi_in;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            chk("stable_cnt", stable_cnt, m_cnt);
            chk("tid", tid, m_tid);
            chk("estat_is", 64'(estat_is), 64'(m_is()));
            chk("has_int", 64'(has_int), 64'(m_has));
            chk("csr_rvalue", csr_rvalue, m_rd(csr_rnum));
            chk("csr_hit", 64'(csr_hit), 64'(csr_rnum inside {14'h40, 14'h41, 14'h42, 14'h44}));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
        csr_we = 1; csr_wnum = n; csr_wmask = m; csr_wvalue = v;
        tick(1);
        csr_we = 0;
    endtask

    logic [13:0] nums [6] = '{14'h40, 14'h41, 14'h42, 14'h44, 14'h43, 14'h00};

    initial begin
        reset = 1; csr_we = 0; csr_wnum = 0; csr_wmask = 0; csr_wvalue = 0;
        csr_rnum = 14'h42; hw_int_in = 0; ipi_in = 0; swi = 0; ecfg_lie = 0; crmd_ie = 0;
        tick(2);
        reset = 0;
        tick(10);
        chk("idle_cnt", stable_cnt, 10);
        chk("idle_has_int", 64'(has_int), 0);
        chk("idle_tval", csr_rvalue, 0);
        csr_rnum = 14'h41; #1;
        chk("idle_tcfg", csr_rvalue, 0);
        chk("idle_hit", 64'(csr_hit), 1);
        csr_rnum = 14'h42;
        // one-shot, reload 8
        ecfg_lie = 13'h800; crmd_ie = 1;
        wr(14'h41, 32'hFFFF_FFFF, 32'h9);
        chk("os_tval_start", csr_rvalue, 8);
        tick(8);
        chk("os_tval_zero", csr_rvalue, 0);
        chk("os_ti_pre", 64'(estat_is[11]), 0);
        tick(1);
        chk("os_ti", 64'(estat_is[11]), 1);
        chk("os_has_pre", 64'(has_int), 0);
        tick(1);
        chk("os_has", 64'(has_int), 1);
        tick(3);
        chk("os_idle_tval", csr_rvalue, 0);
        wr(14'h44, 32'h1, 32'h1);
        chk("os_clr_ti", 64'(estat_is[11]), 0);
        chk("os_clr_has_hold", 64'(has_int), 1);
        tick(1);
        chk("os_has_fall", 64'(has_int), 0);
        // periodic, reload 4
        wr(14'h41, 32'hFFFF_FFFF, 32'h7);
        tick(5);
        chk("per_ti1", 64'(estat_is[11]), 1);
        chk("per_reload", csr_rvalue, 4);
        wr(14'h44, 32'h1, 32'h1);
        chk("per_clr", 64'(estat_is[11]), 0);
        tick(3);
        chk("per_tval0", csr_rvalue, 0);
        wr(14'h44, 32'h1, 32'h1);
        chk("per_set_wins", 64'(estat_is[11]), 1);
        chk("per_reload2", csr_rvalue, 4);
        tick(1);
        chk("rst_pre_tval", csr_rvalue, 3);
        chk("rst_pre_has", 64'(has_int), 1);
        reset = 1;
        tick(1);
        reset = 0;
        chk("rst_tval", csr_rvalue, 0);
        chk("rst_ti", 64'(estat_is[11]), 0);
        chk("rst_has", 64'(has_int), 0);
        tick(3);
        chk("rst_idle_tval", csr_rvalue, 0);
        // hw line 3 -> IS bit 5, two-cycle latency
        ecfg_lie = 13'h020; hw_int_in = 8'h08;
        tick(1);
        hw_int_in = 0;
        chk("hw_lat1", 64'(has_int), 0);
        tick(1);
        chk("hw_lat2", 64'(has_int), 1);
        tick(1);
        chk("hw_fall", 64'(has_int), 0);
        crmd_ie = 0; hw_int_in = 8'h08;
        tick(1);
        hw_int_in = 0;
        tick(1);
        chk("ie_mask", 64'(has_int), 0);
        crmd_ie = 1;
        // TVAL write ignored, En=0 freezes
        wr(14'h41, 32'hFFFF_FFFF, 32'h41);
        tick(5);
        chk("cnt_59", csr_rvalue, 59);
        wr(14'h42, 32'hFFFF_FFFF, 32'h123);
        chk("tval_wr_ignored", csr_rvalue, 58);
        wr(14'h41, 32'hFFFF_FFFF, 32'h40);
        chk("freeze", csr_rvalue, 58);
        tick(5);
        chk("freeze_hold", csr_rvalue, 58);
        // TID masked write
        wr(14'h40, 32'h0000_FFFF, 32'h1234_5678);
        chk("tid_masked", tid, 32'h0000_5678);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            hw_int_in = 8'($urandom);
            ipi_in    = 1'($urandom_range(0, 1));
            swi       = 2'($urandom);
            ecfg_lie  = 13'($urandom);
            crmd_ie   = $urandom_range(0, 3) != 0;
            csr_rnum  = nums[$urandom_range(0, 5)];
            csr_we    = $urandom_range(0, 3) == 0;
            csr_wnum  = nums[$urandom_range(0, 5)];
            csr_wmask = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom;
            csr_wvalue = csr_wnum == 14'h41 ? 32'($urandom_range(0, 31)) :
                         csr_wnum == 14'h44 ? 32'($urandom_range(0, 1)) : $urandom;
            reset     = $urandom_range(0, 299) == 0;
            tick(1);
        end
        reset = 0; csr_we = 0;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/csr_timer_intc.md
# csr_timer_intc

Timer and interrupt-pending controller for the CSR unit. It owns the TID, TCFG, TVAL and TICLR CSRs, the 64-bit stable counter used by the rdcnt instructions, and the ESTAT.IS pending vector. From these it produces the registered `has_int` request that the WB stage forwards to ID. It sits beside the CSR unit in WB, shares that unit's CSR write strobe, and returns read data for its own CSR numbers.

## Interface
- `TIMER_W`, default 32: implemented TVAL/InitVal width, legal range 8..32. TCFG/TVAL bits at and above TIMER_W read 0.
- `TID_RST`, default 32'h0: TID reset value.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `csr_we`  in  1  CSR write strobe, already qualified by ws_valid
- `csr_wnum`  in  14  CSR write number
- `csr_wmask`  in  32  write bit mask
- `csr_wvalue`  in  32  write data
- `csr_rnum`  in  14  CSR read number
- `csr_rvalue`  out  32  read data for owned CSRs, 0 otherwise; combinational
- `csr_hit`  out  1  csr_rnum is 0x40, 0x41, 0x42 or 0x44
- `hw_int_in`  in  8  external interrupt lines, level
- `ipi_in`  in  1  inter-processor interrupt, level
- `swi`  in  2  ESTAT.IS[1:0] held by the CSR unit
- `ecfg_lie`  in  13  ECFG.LIE
- `crmd_ie`  in  1  CRMD.IE
- `estat_is`  out  13  pending vector {ipi, TI, 0, hw[7:0], swi}
- `has_int`  out  1  registered interrupt request
- `tid`  out  32  TID value
- `stable_cnt`  out  64  free-running counter

## Operation
- **Stable counter.** +1 every cycle. Wraps from 2^64-1 to 0.
- **TID (0x40).** Masked write: `new = (old & ~wmask) | (wvalue & wmask)`.
- **TCFG (0x41) fields.**
  - bit0 = En.
  - bit1 = Periodic.
  - bits[TIMER_W-1:2] = InitVal.
  - Reload value is `{InitVal, 2'b00}`.
  - Written as a masked write.
- **TVAL (0x42).** Read-only; writes are ignored.
- **TICLR (0x44).** Reads 0. A write with `wmask[0] & wvalue[0]` clears TI.
- **Timer FSM, state IDLE.** Entered at reset. TVAL holds its value.
- **Timer FSM, state COUNT, TVAL != 0.** TVAL decrements by 1.
- **Timer FSM, state COUNT, TVAL == 0.** TI is set.
  - Periodic: TVAL reloads and the FSM stays in COUNT.
  - One-shot: the FSM goes to IDLE and TVAL stays 0.
- **TCFG write (highest priority).**
  - Resulting En=1: TVAL reloads and the FSM goes to COUNT, regardless of current state.
  - Resulting En=0: the FSM goes to IDLE and TVAL freezes.
- **Reload value of 0 with En=1.** Expiry (TI set) occurs in the next cycle.
- **Simultaneous events.**
  - Timer expiry and a TICLR clear in the same cycle: TI ends at 1 (set wins).
  - TCFG write and expiry in the same cycle: the write wins and TI is not set.
- **Interrupt inputs.** hw_int_in and ipi_in are registered once before entering estat_is. swi is used directly.
- **has_int.** Next-cycle value is `crmd_ie & |(estat_is & ecfg_lie)`.

## Timing
- **Reset values.**
  - stable_cnt = 0, TVAL = 0, TCFG = 0, TI = 0.
  - tid = TID_RST.
  - estat_is = {11'b0, swi}.
  - has_int = 0.
  - FSM = IDLE.
- **Write visibility.** A CSR write takes effect at the clock edge ending the strobe cycle. A read in the following cycle returns the new value.
- **TCFG write sequence.** TCFG written with En=1, InitVal=N at edge k:
  - TVAL = 4N after edge k.
  - TVAL = 0 after edge k+4N.
  - TI = 1 after edge k+4N+1.
- **has_int latency.**
  - hw_int_in / ipi_in to has_int: 2 cycles.
  - TI set to has_int: 1 cycle.
  - swi, ecfg_lie or crmd_ie change to has_int: 1 cycle.
- **has_int level.** has_int is a level signal. It does not clear on exception entry; the CSR unit clearing CRMD.IE drops it one cycle later.
- **Reset mid-count.** Returns every register to its reset value in one edge; no pending TI survives.

## Structure
- **Shared package (used by this block and the CSR unit).**
  - CSR number constants: 0x40 TID, 0x41 TCFG, 0x42 TVAL, 0x44 TICLR.
  - TCFG field positions.
  - IS bit indices: TI = 11, IPI = 12.
  - Timer FSM state enum.
- **Sub-module `csr_timer_core`.** Contains the TCFG/TVAL registers, the FSM and TI. It receives decoded write/clear strobes.
- **Top level.** Keeps CSR decode, TID, stable counter, input registers and has_int.

## Test plan
- **Reset, then idle 10 cycles.** stable_cnt = 10, has_int = 0, TVAL = 0. Read 0x41 returns 0 and csr_hit = 1.
- **One-shot timer.** Write TCFG = 0x0000_0009 (En, InitVal = 2, reload 8); ecfg_lie[11] = 1, crmd_ie = 1.
  - TVAL counts 8..0, then TI sets.
  - has_int rises 10 cycles after the write edge and the FSM returns to IDLE.
  - Write TICLR = 1: TI = 0 and has_int falls one cycle later.
- **Periodic timer.** Write TCFG = 0x0000_0007 (En, Periodic, reload 4).
  - TI sets every 5 cycles while TVAL cycles 4..0.
  - TICLR issued in the same cycle as the second expiry leaves TI = 1.
- **Masking and edge cases.**
  - hw_int_in[3] pulsed with ecfg_lie[5] = 1: has_int follows with 2-cycle latency.
  - crmd_ie = 0 holds has_int = 0.
  - A TVAL write is ignored.
  - TCFG En=0 mid-count freezes TVAL.
- **TID masked write.** Write TID wmask = 0x0000_FFFF, wvalue = 0x1234_5678 from 0: tid = 0x0000_5678.
- **Reset mid-count.** Asserting reset while TVAL = 3 in COUNT gives TVAL = 0, IDLE and TI = 0 on the next edge.
